uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit controller for the UART IP. It sits between the AXI-lite register block and the `txd` pin. Byte writes to `tx_data` are buffered in a small FIFO. A baud-tick counter paced by `tx_baud` and a frame state machine then serialise each byte with start, optional parity and stop bits, as configured by `uart_ctrl`. Status outputs feed back into the register block for readback.

## Interface
- `C_S_AXI_DATA_WIDTH`, default 32: width of the register inputs.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of two, minimum 2.
- `S_AXI_ACLK`  in  1  the single clock.
- `S_AXI_ARESETN`  in  1  reset, asynchronous assert, active-low.
- `uart_ctrl`  in  C_S_AXI_DATA_WIDTH  control bits:
  - [0] `tx_en`
  - [1] `par_en`
  - [2] `par_odd`
  - [3] `two_stop`
  - [4] `flush` (level)
  - other bits are ignored.
- `tx_baud`  in  C_S_AXI_DATA_WIDTH  bits [15:0] hold divisor D; each bit lasts D+1 clocks. Other bits are ignored.
- `tx_data`  in  C_S_AXI_DATA_WIDTH  byte source; only bits [7:0] are used.
- `tx_wr`  in  1  single-cycle push strobe for `tx_data[7:0]`.
- `txd`  out  1  serial line, idle high.
- `tx_busy`  out  1  high whenever the FSM is not in IDLE.
- `fifo_empty`  out  1  FIFO holds no entries.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.
- `tx_done`  out  1  one-cycle pulse at the end of each frame.
- `tx_ovf`  out  1  one-cycle pulse when a push is dropped.

## Operation
**Reset values**
- `txd`=1, `tx_busy`=0, `fifo_empty`=1, `fifo_full`=0, `fifo_level`=0, `tx_done`=0, `tx_ovf`=0.
- FSM=IDLE; FIFO pointers are zero.

**FIFO**
- Circular buffer with read and write pointers one bit wider than the address; the pointers wrap naturally.
- `tx_wr` while not full: the byte is pushed.
- `tx_wr` while full with no pop in the same cycle: the byte is dropped and `tx_ovf` pulses.
- Push and pop in the same cycle while full: the push is accepted, the level is unchanged, and there is no overflow.
- `flush`=1: both pointers are cleared every cycle it is held. A `tx_wr` in a flush cycle is discarded without `tx_ovf`. A frame already in flight is unaffected.

**FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** if `tx_en`=1, FIFO not empty and `flush`=0, then:
  - pop the head into the shift register;
  - latch D, `par_en`, `par_odd` and `two_stop` for the whole frame;
  - go to START.
- **START:** `txd`=0 for D+1 clocks, then DATA.
- **DATA:** 8 bits, LSB first, each D+1 clocks. A 3-bit counter tracks the bits. After bit 7, go to PARITY if `par_en`, else STOP.
- **PARITY:** drive the XOR of the 8 data bits when `par_odd`=0 (even parity), or its inverse when `par_odd`=1 (odd parity), for D+1 clocks.
- **STOP:** `txd`=1 for (D+1) clocks, or 2·(D+1) clocks if `two_stop`.
- **Last STOP cycle:**
  - `tx_done` pulses.
  - If the IDLE pop condition holds, pop and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.

**Baud counter**
- 16-bit down-counter, loaded with D on every state or bit entry.
- The bit ends when the counter reaches 0.
- D=0 gives one clock per bit.

**Configuration changes**
- `tx_en` deasserted mid-frame: the current frame completes and no further pop occurs.
- Changes to `tx_baud` or `uart_ctrl[3:1]` mid-frame affect only the next frame.

**Reset mid-frame:** `txd` goes high immediately (asynchronously), the frame is abandoned and the FIFO is cleared.

## Timing
- `txd` is driven from a register.
- A pop in cycle N gives `txd`=0 from cycle N+1.
- `tx_wr` in cycle N with FIFO empty, IDLE and `tx_en`=1:
  - `fifo_empty` drops at N+1;
  - the pop occurs at N+1;
  - `txd` goes low at N+2.
- Frame length in clocks = (D+1)·(10 + par_en + two_stop).
- `fifo_level`, `fifo_full` and `fifo_empty` are registered and update the cycle after a push or pop.
- `tx_done` and `tx_ovf` are high for exactly one cycle.

## Test plan
- **Single byte:** D=3, 8N1, push 0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; 40 clocks total; one `tx_done` pulse; `tx_busy` falls after the frame.
- **Parity and two stop bits:** D=1, `par_en`=1 with `par_odd`=0, then `par_odd`=1, `two_stop`=1, push 0x07 → parity bit 1 (even), then 0 (odd); stop lasts 4 clocks; 24-clock frame.
- **FIFO fill and overflow:** `tx_en`=0, push 9 bytes with DEPTH=8 → `fifo_full`=1, `fifo_level`=8, one `tx_ovf` pulse on the 9th push. Then set `tx_en`=1 → 8 back-to-back frames with no idle gap and 8 `tx_done` pulses.
- **Wrap and concurrency:** keep pushing during transmission for 20 bytes, including a push in the same cycle as a pop while full → all 20 bytes are sent in order with no `tx_ovf`.
- **Flush and enable:** pulse `flush` mid-frame with 3 bytes queued → the current frame completes, the FIFO is empty and nothing further is sent. Deassert `tx_en` mid-frame → that frame completes and the next queued byte is held.
- **Async reset mid-DATA:** assert `S_AXI_ARESETN`=0 → `txd`=1 and `fifo_level`=0 without waiting for a clock edge; after release, a new push transmits normally.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: transmit side of the UART IP.
// Bytes written through the register block are queued in a small FIFO and
// serialised onto txd as start / 8 data (LSB first) / optional parity /
// one or two stop bits. The frame configuration is captured when a byte is
// popped, so register changes mid-frame only affect the following frame.
module uart_tx_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   uart_ctrl,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   tx_baud,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   tx_data,
  input  logic                            tx_wr,
  output logic                            txd,
  output logic                            tx_busy,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            tx_done,
  output logic                            tx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // control field decode
  logic w_tx_en, w_par_en, w_par_odd, w_two_stop, w_flush;
  assign w_tx_en    = uart_ctrl[0];
  assign w_par_en   = uart_ctrl[1];
  assign w_par_odd  = uart_ctrl[2];
  assign w_two_stop = uart_ctrl[3];
  assign w_flush    = uart_ctrl[4];

  // register bits that carry no meaning for the transmitter
  logic w_unused;
  assign w_unused = ^{uart_ctrl[C_S_AXI_DATA_WIDTH-1:5],
                      tx_baud[C_S_AXI_DATA_WIDTH-1:16],
                      tx_data[C_S_AXI_DATA_WIDTH-1:8]};

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [AW:0] w_level;
  logic        w_empty, w_full;
  logic        w_can_pop, w_pop, w_push, w_drop;
  logic [7:0]  w_head;

  assign w_level   = r_wptr - r_rptr;
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (w_level == DEPTH_L);
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  // flush blocks the pop so a flushed entry can never start a frame
  assign w_can_pop = w_tx_en & ~w_empty & ~w_flush;
  // a full FIFO still accepts a push when the same cycle pops an entry
  assign w_push    = tx_wr & ~w_flush & (~w_full | w_pop);
  assign w_drop    = tx_wr & ~w_flush &  w_full & ~w_pop;

  // pointer update; flush clears both pointers every cycle it is held
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // storage array; contents need no reset since the pointers gate reads
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= tx_data[7:0];
  end

  // --------------------------------------------------------- frame engine
  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, r_div;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par_bit, r_par_en, r_two_stop, r_stop2;
  logic        r_txd, r_ovf;

  logic        w_bit_end, w_reload, w_shift, w_stop_adv, w_done, w_txd_nxt;

  assign w_bit_end = (r_cnt == 16'd0);

  // state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // next state, pop request, counter reload and next txd level
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_reload    = 1'b0;
    w_shift     = 1'b0;
    w_stop_adv  = 1'b0;
    w_done      = 1'b0;
    w_txd_nxt   = r_txd;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_can_pop) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_reload    = 1'b1;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_reload = 1'b1;
          if (r_bit == 3'd7) begin
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_txd_nxt   = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_txd_nxt   = 1'b1;
            end
          end else begin
            // the next data bit is the one just above the current LSB
            w_shift   = 1'b1;
            w_txd_nxt = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_reload    = 1'b1;
          w_txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && !r_stop2) begin
            w_stop_adv = 1'b1;
            w_reload   = 1'b1;
          end else begin
            w_done = 1'b1;
            if (w_can_pop) begin
              // back-to-back frame: start bit follows the stop bit directly
              w_pop       = 1'b1;
              w_state_nxt = S_START;
              w_txd_nxt   = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_txd_nxt   = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // frame datapath: latch byte and config on pop, then pace the bits
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_cnt      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
    end else if (w_pop) begin
      r_shift    <= w_head;
      r_div      <= tx_baud[15:0];
      r_cnt      <= tx_baud[15:0];
      r_par_en   <= w_par_en;
      r_two_stop <= w_two_stop;
      // parity polarity is folded in here so par_odd needs no own latch
      r_par_bit  <= (^w_head) ^ w_par_odd;
      r_bit      <= '0;
      r_stop2    <= 1'b0;
    end else begin
      if (w_reload)          r_cnt <= r_div;
      else if (!w_bit_end)   r_cnt <= r_cnt - 16'd1;
      if (w_shift) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (w_stop_adv) r_stop2 <= 1'b1;
    end
  end

  // registered line driver and overflow pulse; line idles high in reset
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_txd <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      r_txd <= w_txd_nxt;
      r_ovf <= w_drop;
    end
  end

  assign txd        = r_txd;
  assign tx_busy    = (r_state != S_IDLE);
  assign tx_done    = w_done;
  assign tx_ovf     = r_ovf;
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table-driven frame vectors, hand sequences for
// FIFO / flush / enable / reset corners, and random traffic scored by a
// line-decoding receiver model.
module tb_uart_tx_ctrl;
  localparam int W = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] ctrl, baud, data;
  logic wr;
  logic txd, busy, empty, full, done, ovf;
  logic [$clog2(DEPTH):0] level;

  uart_tx_ctrl #(.C_S_AXI_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .uart_ctrl(ctrl), .tx_baud(baud), .tx_data(data), .tx_wr(wr),
    .txd(txd), .tx_busy(busy), .fifo_empty(empty), .fifo_full(full),
    .fifo_level(level), .tx_done(done), .tx_ovf(ovf));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  // ---- receiver model: decodes txd using the configuration the bench set
  int   m_d = 0;
  bit   m_pe = 0, m_po = 0, m_ts = 0;
  bit   m_in = 0;
  int   m_cyc, m_k;
  logic [11:0] m_bits;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int   m_err = 0, done_cnt = 0, ovf_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in = 0;
    end else begin
      if (done) done_cnt++;
      if (ovf)  ovf_cnt++;
      if (!m_in) begin
        if (txd == 1'b0) begin
          m_in = 1; m_cyc = 0; m_bits = '0; m_k = 1;
        end
      end else begin
        m_cyc++;
        if (m_cyc % (m_d + 1) == 0) begin
          m_bits[m_k] = txd;
          m_k++;
          if (m_k == 10 + int'(m_pe) + int'(m_ts)) begin
            if (m_pe && m_bits[9] != ((^m_bits[8:1]) ^ m_po)) m_err++;
            if (m_bits[9 + int'(m_pe)] != 1'b1) m_err++;
            if (m_ts && m_bits[10 + int'(m_pe)] != 1'b1) m_err++;
            rx_q.push_back(m_bits[8:1]);
            m_in = 0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---- helpers
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input bit en, input bit pe, input bit po,
                                       input bit ts, input bit fl);
    return {27'b0, fl, ts, po, pe, en};
  endfunction

  task automatic setcfg(input int d, input bit pe, input bit po, input bit ts);
    m_d = d; m_pe = pe; m_po = po; m_ts = ts;
    baud = W'(d);
  endtask

  task automatic clr();
    rx_q.delete(); exp_q.delete();
    done_cnt = 0; ovf_cnt = 0; m_err = 0;
  endtask

  task automatic push(input logic [7:0] b);
    data = {24'b0, b};
    wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!busy && n < 50) begin step(); n++; end
    if (n >= 50) tmo(nm);
  endtask

  task automatic wait_not_busy(input string nm);
    int n = 0;
    while (busy && n < 2000) begin step(); n++; end
    if (n >= 2000) tmo(nm);
  endtask

  task automatic wait_drained(input string nm);
    int n = 0;
    while ((busy || !empty) && n < 8000) begin step(); n++; end
    if (n >= 8000) tmo(nm);
  endtask

  task automatic cmp_q(input string nm);
    int mism = 0;
    chk({nm, "_cnt"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mism++;
    chk({nm, "_bytes"}, mism, 0);
  endtask

  // ---- frame vectors with hand-derived length and parity level
  typedef struct {
    logic [7:0] b;
    int d;
    bit pe, po, ts;
    int exp_len;
    bit exp_par;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    logic exp_bits[$];
    int i = 0, errs = 0, dpos = -1, dcnt = 0;
    logic par = 1'bx;
    string s;
    s = $sformatf("v%0d", idx);
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(v.b[k]);
    if (v.pe) exp_bits.push_back((^v.b) ^ v.po);
    exp_bits.push_back(1'b1);
    if (v.ts) exp_bits.push_back(1'b1);
    clr();
    setcfg(v.d, v.pe, v.po, v.ts);
    ctrl = mk(1, v.pe, v.po, v.ts, 0);
    data = {24'b0, v.b};
    wr = 1'b1;
    step();
    wr = 1'b0;
    chk({s, "_empty_drop"}, empty, 0);
    chk({s, "_txd_before_pop"}, txd, 1);
    step();
    while (busy && i < 400) begin
      if (i / (v.d + 1) < exp_bits.size()) begin
        if (txd !== exp_bits[i / (v.d + 1)]) errs++;
      end else errs++;
      if (v.pe && i == 9 * (v.d + 1)) par = txd;
      if (done) begin dcnt++; dpos = i; end
      i++;
      step();
    end
    chk({s, "_len"}, i, v.exp_len);
    chk({s, "_wave"}, errs, 0);
    chk({s, "_done_cnt"}, dcnt, 1);
    chk({s, "_done_pos"}, dpos, v.exp_len - 1);
    if (v.pe) chk({s, "_parity"}, par, v.exp_par);
    chk({s, "_idle_txd"}, txd, 1);
    step();
    chk({s, "_rx_cnt"}, rx_q.size(), 1);
    if (rx_q.size() > 0) chk({s, "_rx_byte"}, rx_q[0], v.b);
  endtask

  initial begin
    int t, n, start;
    logic [7:0] b;
    logic [7:0] fill[$];
    ctrl = '0; baud = '0; data = '0; wr = 1'b0;

    // ---- reset state
    step(); step();
    chk("rst_txd_in_reset", txd, 1);
    rst_n = 1'b1;
    step();
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);

    // ---- table-driven single frames
    vecs[0] = '{b: 8'hA5, d: 3, pe: 0, po: 0, ts: 0, exp_len: 40, exp_par: 0};
    vecs[1] = '{b: 8'h07, d: 1, pe: 1, po: 0, ts: 0, exp_len: 22, exp_par: 1};
    vecs[2] = '{b: 8'h07, d: 1, pe: 1, po: 1, ts: 1, exp_len: 24, exp_par: 0};
    vecs[3] = '{b: 8'h00, d: 0, pe: 1, po: 0, ts: 1, exp_len: 12, exp_par: 0};
    vecs[4] = '{b: 8'hFF, d: 2, pe: 1, po: 1, ts: 0, exp_len: 33, exp_par: 1};
    vecs[5] = '{b: 8'h3C, d: 5, pe: 0, po: 0, ts: 1, exp_len: 66, exp_par: 0};
    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // ---- FIFO fill, overflow, then back-to-back drain
    clr();
    setcfg(0, 0, 0, 0);
    ctrl = mk(0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      b = 8'(8'h40 + k);
      if (k < 8) exp_q.push_back(b);
      push(b);
    end
    step();
    chk("fill_level", level, 8);
    chk("fill_full", full, 1);
    chk("fill_ovf_pulses", ovf_cnt, 1);
    ctrl = mk(1, 0, 0, 0, 0);
    wait_busy("b2b_start");
    t = 0;
    while (busy && t < 500) begin step(); t++; end
    chk("b2b_len", t, 80);
    chk("b2b_done", done_cnt, 8);
    chk("b2b_err", m_err, 0);
    chk("b2b_empty", empty, 1);
    cmp_q("b2b");

    // ---- random traffic; round 0 hits push+pop while full and wraps
    for (int r = 0; r < 4; r++) begin
      bit pe, po, ts;
      clr();
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      setcfg($urandom_range(0, 2), pe, po, ts);
      n = (r == 0) ? 20 : $urandom_range(6, 14);
      if (r == 0) begin
        ctrl = mk(0, pe, po, ts, 0);
        for (int k = 0; k < 8; k++) begin
          b = 8'($urandom);
          exp_q.push_back(b);
          push(b);
        end
        b = 8'($urandom);
        exp_q.push_back(b);
        ctrl = mk(1, pe, po, ts, 0);
        data = {24'b0, b};
        wr = 1'b1;
        step();
        wr = 1'b0;
        chk("pushpop_level", level, 8);
        chk("pushpop_ovf", ovf, 0);
        start = 9;
      end else begin
        ctrl = mk(1, pe, po, ts, 0);
        start = 0;
      end
      for (int k = start; k < n; k++) begin
        t = 0;
        while (full && t < 500) begin step(); t++; end
        if (t >= 500) tmo("rnd_not_full");
        repeat ($urandom_range(0, 3)) step();
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end
      wait_drained("rnd_drain");
      step();
      cmp_q($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_ovf", r), ovf_cnt, 0);
      chk($sformatf("rnd%0d_done", r), done_cnt, n);
      chk($sformatf("rnd%0d_err", r), m_err, 0);
    end

    // ---- flush mid-frame with 3 bytes queued, push during flush discarded
    clr();
    setcfg(1, 0, 0, 0);
    ctrl = mk(0, 0, 0, 0, 0);
    push(8'h3A); push(8'h3B); push(8'h3C); push(8'h3D);
    ctrl = mk(1, 0, 0, 0, 0);
    wait_busy("flush_start");
    repeat (5) step();
    ctrl = mk(1, 0, 0, 0, 1);
    data = 32'h77;
    wr = 1'b1;
    step();
    wr = 1'b0;
    ctrl = mk(1, 0, 0, 0, 0);
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_busy_kept", busy, 1);
    wait_not_busy("flush_end");
    repeat (30) step();
    chk("flush_done", done_cnt, 1);
    chk("flush_rx_cnt", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("flush_rx_byte", rx_q[0], 8'h3A);
    chk("flush_ovf", ovf_cnt, 0);
    chk("flush_idle", busy, 0);

    // ---- tx_en dropped mid-frame holds the next byte
    clr();
    ctrl = mk(1, 0, 0, 0, 0);
    push(8'h11); push(8'h22);
    wait_busy("en_start");
    repeat (4) step();
    ctrl = mk(0, 0, 0, 0, 0);
    wait_not_busy("en_end");
    repeat (30) step();
    chk("en_done", done_cnt, 1);
    chk("en_level_held", level, 1);
    chk("en_rx_cnt", rx_q.size(), 1);
    ctrl = mk(1, 0, 0, 0, 0);
    wait_drained("en_resume");
    step();
    chk("en_rx_cnt2", rx_q.size(), 2);
    if (rx_q.size() > 1) chk("en_rx_byte2", rx_q[1], 8'h22);

    // ---- asynchronous reset in the middle of the data bits
    clr();
    setcfg(3, 0, 0, 0);
    ctrl = mk(1, 0, 0, 0, 0);
    push(8'h00); push(8'h55); push(8'h66);
    wait_busy("arst_start");
    repeat (6) step();
    chk("arst_pre_txd", txd, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_busy", busy, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    clr();
    push(8'h96);
    wait_drained("arst_after");
    step();
    chk("arst_rx_cnt", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("arst_rx_byte", rx_q[0], 8'h96);
    chk("arst_err", m_err, 0);
    chk("arst_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
